trace_capture: RTL and testbench
================================

Name: trace_capture

Overview:
- Downstream dv stage that records packets leaving the DUT (or a stimulus stage) into an on-chip trace RAM.
- Each record is stored in the stimulus memory format: bit[0]=valid, [CW-1:1]=idle-gap count, [MW-1:CW]=packet. A captured trace can be reloaded unchanged as stimulus, and replays with the original timing.
- Single clock domain. After capture stops, the trace is read back through a registered random-access port.

Parameters:
- DW, 64, captured packet width
- DEPTH, 1024, trace RAM depth in records (power of 2)
- CW, 16, control field width: bit[0] valid, [CW-1:1] gap count (CW>=2)
- MW, DW+CW, record width (derived)
- STALL, 1, 1=deassert in_ready when full; 0=always ready, drop and flag overflow
- MAW, $clog2(DEPTH), RAM address width (derived)

Ports:
- clk  input  1  capture and readout clock
- reset  input  1  asynchronous active-high reset
- start  input  1  level/pulse; begins capture from IDLE
- stop  input  1  pulse; ends capture and writes end record
- in_valid  input  1  packet valid from upstream
- in_packet  input  DW  packet data
- in_ready  output  1  capture can accept packet this cycle
- rd_addr  input  MAW  readout address
- rd_data  output  MW  readout record, 1-cycle latency
- count  output  MAW+1  number of packet records written (end record excluded)
- full  output  1  RAM holds DEPTH records
- overflow  output  1  sticky: packet offered and dropped (STALL=0 only)
- done  output  1  capture finished (state DONE)

Behaviour:
- Reset (async, active-high): state=IDLE, wr_addr=0, gap=0, count=0, overflow=0, rd_data=0. in_ready, full and done all read 0. RAM contents are not reset.
- States: IDLE, CAPTURE, FULL, DONE.
- IDLE: in_ready=0; inputs ignored. start=1 -> CAPTURE next cycle with gap=0.
- CAPTURE: in_ready=1.
  - Accept = in_valid & in_ready. On accept, write {in_packet, gap[CW-2:0], 1'b1} at wr_addr, then wr_addr++, count++, gap<=0.
  - Otherwise gap++, saturating at 2^(CW-1)-1.
  - The gap of the first record is the number of cycles between entering CAPTURE and the first accept. Back-to-back accepts give gap=0.
  - The write that fills address DEPTH-1 moves the state to FULL.
  - stop=1 with no accept: write end record {0, gap, 1'b0} at wr_addr (not counted) -> DONE.
  - stop and accept in the same cycle: the packet is written and counted. The end record goes to the next address in the following cycle if space remains -> DONE.
- FULL: full=1, no further writes, no end record.
  - in_ready = (STALL==0). When STALL=0, any in_valid sets overflow.
  - stop -> DONE.
- DONE: done=1, in_ready=0, terminal until reset. start is ignored in FULL and DONE.
- Readout: rd_data <= ram[rd_addr] every clock, in any state. Read and write to the same address in the same cycle return the old contents (read-first).
- count saturates at DEPTH. full = (count==DEPTH).
- Reset mid-capture aborts immediately; RAM contents are retained but undefined as a trace.

Test Plan:
- Basic: start; in_valid on cycles 0,1,5 with packets 0xA,0xB,0xC; stop at cycle 8 -> ram[0]={0xA,gap0,1}, ram[1]={0xB,0,1}, ram[2]={0xC,3,1}, ram[3]={0,2,0}; count=3, done=1.
- Full with STALL=1, DEPTH=8: stream 10 packets back-to-back -> exactly 8 records written; full=1; in_ready drops the cycle after the 8th accept; overflow=0; no end record after stop.
- Overflow with STALL=0, DEPTH=8: 10 packets -> count=8, overflow=1 on the 9th offer and stays set through stop and DONE.
- Gap saturation with CW=4: 20 idle cycles then one packet -> gap field=7.
- Simultaneous stop and accept at count=2 -> packet at ram[2], end record at ram[3], count=3. Repeat at address DEPTH-1 -> FULL then DONE, no end record.
- Async reset asserted mid-CAPTURE, between clock edges -> outputs and counters zero immediately; in_ready=0. A new start restarts capture at address 0.

Source files
------------

// File: rtl/trace_capture_if.sv
// Upstream packet handshake into the trace capture block.
//   in_valid  : packet offered this cycle
//   in_packet : packet payload, DW bits
//   in_ready  : capture accepts the offered packet this cycle
// master drives valid/packet (stimulus or DUT side); slave is the capture block.
interface trace_capture_if #(
  parameter int unsigned DW = 64
);
  logic          in_valid;
  logic [DW-1:0] in_packet;
  logic          in_ready;

  modport master (
    output in_valid,
    output in_packet,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_packet,
    output in_ready
  );
endinterface

// File: rtl/trace_capture.sv
// Records packets into a trace RAM using the stimulus memory record format:
//   bit[0] = valid, [CW-1:1] = idle-gap count, [MW-1:CW] = packet.
// A captured trace can be reloaded as stimulus and replays with the original timing.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   start      : begin capture from idle (level or pulse)
//   stop       : pulse, end capture and write the end record
//   in_if      : packet handshake (slave side)
//   rd_addr    : readout address; rd_data returns the record one cycle later
//   count      : packet records written (end record excluded), saturates at DEPTH
//   full       : RAM holds DEPTH records
//   overflow   : sticky, a packet was offered and dropped while full (STALL=0)
//   done       : capture finished
module trace_capture #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CW    = 16,
  parameter int unsigned STALL = 1,
  localparam int unsigned MW   = DW + CW,
  localparam int unsigned MAW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  trace_capture_if.slave    in_if,
  input  logic [MAW-1:0]    rd_addr,
  output logic [MW-1:0]     rd_data,
  output logic [MAW:0]      count,
  output logic              full,
  output logic              overflow,
  output logic              done
);

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StEndRec,
    StFull,
    StDone
  } state_e;

  localparam logic [CW-2:0] GapMax    = '1;
  localparam logic [MAW:0]  CountFull = (MAW + 1)'(DEPTH);

  state_e          state_q, state_d;
  logic [MAW-1:0]  wr_addr_q, wr_addr_d;
  logic [CW-2:0]   gap_q, gap_d;
  logic [MAW:0]    count_q, count_d;
  logic            overflow_q, overflow_d;
  // Remembers a stop that arrived together with the accept that filled the RAM.
  logic            stop_pend_q, stop_pend_d;

  logic            ready;
  logic            we;
  logic [MW-1:0]   wdata;

  logic [MW-1:0]   mem [DEPTH];

  assign ready = (state_q == StCapture) || ((state_q == StFull) && (STALL == 0));

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    gap_d       = gap_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    stop_pend_d = stop_pend_q;
    we          = 1'b0;
    wdata       = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCapture;
          gap_d   = '0;
        end
      end

      StCapture: begin
        if (in_if.in_valid) begin
          we        = 1'b1;
          wdata     = {in_if.in_packet, gap_q, 1'b1};
          wr_addr_d = wr_addr_q + 1'b1;
          count_d   = count_q + 1'b1;
          gap_d     = '0;
          // All-ones address is DEPTH-1 because DEPTH is a power of two.
          if (&wr_addr_q) begin
            state_d     = StFull;
            stop_pend_d = stop;
          end else if (stop) begin
            state_d = StEndRec;
          end
        end else if (stop) begin
          we      = 1'b1;
          wdata   = {{DW{1'b0}}, gap_q, 1'b0};
          state_d = StDone;
        end else if (gap_q != GapMax) begin
          gap_d = gap_q + 1'b1;
        end
      end

      // End record deferred from a cycle that both accepted and stopped.
      StEndRec: begin
        we      = 1'b1;
        wdata   = {{DW{1'b0}}, gap_q, 1'b0};
        state_d = StDone;
      end

      StFull: begin
        if ((STALL == 0) && in_if.in_valid) begin
          overflow_d = 1'b1;
        end
        if (stop || stop_pend_q) begin
          state_d = StDone;
        end
        stop_pend_d = 1'b0;
      end

      StDone: begin
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_addr_q   <= '0;
      gap_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // Trace RAM is not reset; contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr_q] <= wdata;
    end
  end

  // Read-first: a same-address write this cycle is not visible until the next read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  assign in_if.in_ready = ready;
  assign count          = count_q;
  assign full           = (count_q == CountFull);
  assign overflow       = overflow_q;
  assign done           = (state_q == StDone);

endmodule

// File: tb/tb_trace_capture.sv
// Bench for trace_capture: two instances (STALL=1 and STALL=0) share one directed
// stimulus stream. A record-list model predicts every output each cycle, and
// literal expectations pin the model on the documented scenarios.
module tb_trace_capture;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned MW    = DW + CW;
  localparam int unsigned MAW   = 3;
  localparam int          GMAX  = (1 << (CW - 1)) - 1;

  localparam int PIdle = 0, PCap = 1, PEnd = 2, PFull = 3, PDone = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           in_valid = 1'b0;
  logic [DW-1:0]  in_packet = '0;
  logic [MAW-1:0] rd_addr = '0;
  bit             sweep = 1'b1;

  int tests = 0;
  int fails = 0;

  trace_capture_if #(.DW(DW)) if_s ();
  trace_capture_if #(.DW(DW)) if_d ();

  assign if_s.in_valid  = in_valid;
  assign if_s.in_packet = in_packet;
  assign if_d.in_valid  = in_valid;
  assign if_d.in_packet = in_packet;

  logic [MW-1:0] rd_data_s, rd_data_d;
  logic [MAW:0]  count_s, count_d;
  logic          full_s, full_d, ovf_s, ovf_d, done_s, done_d;

  trace_capture #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .STALL(1)) u_stall (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .in_if(if_s),
    .rd_addr(rd_addr), .rd_data(rd_data_s), .count(count_s), .full(full_s),
    .overflow(ovf_s), .done(done_s)
  );

  trace_capture #(.DW(DW), .DEPTH(DEPTH), .CW(CW), .STALL(0)) u_drop (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .in_if(if_d),
    .rd_addr(rd_addr), .rd_data(rd_data_d), .count(count_d), .full(full_d),
    .overflow(ovf_d), .done(done_d)
  );

  always #5 clk = ~clk;

  // ---------------- model: a list of stored records per instance ----------------
  int            m_ph   [2];
  int            m_len  [2];
  int            m_cnt  [2];
  int            m_gap  [2];
  bit            m_ovf  [2];
  bit            m_pend [2];
  logic [MW-1:0] m_ram  [2][DEPTH];
  bit            m_known[2][DEPTH];
  logic [MW-1:0] m_rd   [2];
  bit            m_rd_ok[2];

  function automatic logic [MW-1:0] mk_rec(input logic [DW-1:0] p, input int g, input bit v);
    logic [CW-2:0] gf;
    gf = g[CW-2:0];
    return {p, gf, v};
  endfunction

  task automatic model_reset(input int k);
    m_ph[k] = PIdle; m_len[k] = 0; m_cnt[k] = 0; m_gap[k] = 0;
    m_ovf[k] = 1'b0; m_pend[k] = 1'b0; m_rd[k] = '0; m_rd_ok[k] = 1'b1;
  endtask

  task automatic store(input int k, input logic [MW-1:0] rec);
    m_ram[k][m_len[k]]   = rec;
    m_known[k][m_len[k]] = 1'b1;
    m_len[k]             = m_len[k] + 1;
  endtask

  task automatic model_step(input int k, input bit stall);
    // readout returns what was stored before this edge
    m_rd[k]    = m_ram[k][rd_addr];
    m_rd_ok[k] = m_known[k][rd_addr];
    case (m_ph[k])
      PIdle: if (start) begin m_ph[k] = PCap; m_gap[k] = 0; end
      PCap: begin
        if (in_valid) begin
          store(k, mk_rec(in_packet, m_gap[k], 1'b1));
          m_cnt[k] = m_cnt[k] + 1;
          m_gap[k] = 0;
          if (m_len[k] == DEPTH) begin m_ph[k] = PFull; m_pend[k] = stop; end
          else if (stop) m_ph[k] = PEnd;
        end else if (stop) begin
          store(k, mk_rec('0, m_gap[k], 1'b0));
          m_ph[k] = PDone;
        end else begin
          m_gap[k] = (m_gap[k] < GMAX) ? m_gap[k] + 1 : GMAX;
        end
      end
      PEnd: begin store(k, mk_rec('0, 0, 1'b0)); m_ph[k] = PDone; end
      PFull: begin
        if (!stall && in_valid) m_ovf[k] = 1'b1;
        if (stop || m_pend[k]) m_ph[k] = PDone;
        m_pend[k] = 1'b0;
      end
      default: ;
    endcase
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      for (int a = 0; a < DEPTH; a++) begin m_known[k][a] = 1'b0; m_ram[k][a] = '0; end
    end
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset(0); model_reset(1);
      end else begin
        model_step(0, 1'b1);
        model_step(1, 1'b0);
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("s.in_ready", 32'(if_s.in_ready), 32'(m_ph[0] == PCap));
      check("d.in_ready", 32'(if_d.in_ready), 32'(m_ph[1] == PCap || m_ph[1] == PFull));
      check("s.count", 32'(count_s), 32'(m_cnt[0]));
      check("d.count", 32'(count_d), 32'(m_cnt[1]));
      check("s.full", 32'(full_s), 32'(m_cnt[0] == DEPTH));
      check("d.full", 32'(full_d), 32'(m_cnt[1] == DEPTH));
      check("s.overflow", 32'(ovf_s), 32'(m_ovf[0]));
      check("d.overflow", 32'(ovf_d), 32'(m_ovf[1]));
      check("s.done", 32'(done_s), 32'(m_ph[0] == PDone));
      check("d.done", 32'(done_d), 32'(m_ph[1] == PDone));
      if (m_rd_ok[0]) check("s.rd_data", 32'(rd_data_s), 32'(m_rd[0]));
      if (m_rd_ok[1]) check("d.rd_data", 32'(rd_data_d), 32'(m_rd[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
    if (sweep) rd_addr = rd_addr + 1'b1;
  endtask

  task automatic cyc(input bit st, input bit v, input logic [DW-1:0] p, input bit sp);
    start = st; in_valid = v; in_packet = p; stop = sp;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    start = 1'b0; stop = 1'b0; in_valid = 1'b0; sweep = 1'b1;
    reset = 1'b1; tick(); reset = 1'b0; tick();
  endtask

  task automatic read_chk(input string name, input int a, input logic [MW-1:0] e);
    sweep = 1'b0;
    rd_addr = a[MAW-1:0];
    tick();
    check({"s.", name}, 32'(rd_data_s), 32'(e));
    check({"d.", name}, 32'(rd_data_d), 32'(e));
  endtask

  initial begin
    tick(); tick();
    // reset state, still in reset
    check("rst.count", 32'(count_s), 32'd0);
    check("rst.in_ready", 32'(if_s.in_ready), 32'd0);
    check("rst.done", 32'(done_s), 32'd0);
    check("rst.full", 32'(full_d), 32'd0);
    check("rst.overflow", 32'(ovf_d), 32'd0);
    check("rst.rd_data", 32'(rd_data_s), 32'd0);
    reset = 1'b0; tick();

    // basic: packets on capture cycles 0,1,5, stop on cycle 8
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 16'h000A, 1'b0);
    cyc(1'b0, 1'b1, 16'h000B, 1'b0);
    idle(3);
    cyc(1'b0, 1'b1, 16'h000C, 1'b0);
    idle(2);
    cyc(1'b0, 1'b0, '0, 1'b1);
    idle(1);
    check("basic.count", 32'(count_s), 32'd3);
    check("basic.done", 32'(done_s), 32'd1);
    read_chk("basic.ram0", 0, 20'h000A1);
    read_chk("basic.ram1", 1, 20'h000B1);
    read_chk("basic.ram2", 2, 20'h000C7);
    read_chk("basic.ram3", 3, 20'h00004);

    // gap saturation: 20 idle cycles -> gap field 7
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    idle(20);
    cyc(1'b0, 1'b1, 16'h0005, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1);
    idle(1);
    read_chk("gapsat.ram0", 0, 20'h0005F);
    read_chk("gapsat.end", 1, 20'h00000);

    // stop with accept at count=2; ram[3] still holds 0x00004 from basic
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0001, 1'b0);
    cyc(1'b0, 1'b1, 16'h0002, 1'b0);
    sweep = 1'b0; rd_addr = 3'd3;
    cyc(1'b0, 1'b1, 16'h0003, 1'b1);
    idle(1);
    check("rdfirst.old", 32'(rd_data_s), 32'h00004);
    idle(1);
    check("rdfirst.new", 32'(rd_data_s), 32'h00000);
    check("stopacc.count", 32'(count_s), 32'd3);
    check("stopacc.done", 32'(done_s), 32'd1);
    read_chk("stopacc.ram2", 2, 20'h00031);

    // fill: 10 back-to-back packets
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, 16'(16'h10 + i), 1'b0);
      if (i == 7) begin
        check("fill.s_ready_drop", 32'(if_s.in_ready), 32'd0);
        check("fill.d_ready", 32'(if_d.in_ready), 32'd1);
        check("fill.full", 32'(full_s), 32'd1);
        check("fill.d_ovf_pre", 32'(ovf_d), 32'd0);
      end
      if (i == 8) check("fill.d_ovf_9th", 32'(ovf_d), 32'd1);
    end
    cyc(1'b0, 1'b0, '0, 1'b1);
    idle(1);
    check("fill.s_count", 32'(count_s), 32'd8);
    check("fill.d_count", 32'(count_d), 32'd8);
    check("fill.s_ovf", 32'(ovf_s), 32'd0);
    check("fill.d_ovf_done", 32'(ovf_d), 32'd1);
    check("fill.d_done", 32'(done_d), 32'd1);
    read_chk("fill.ram0", 0, 20'h00101);
    read_chk("fill.ram7", 7, 20'h00171);

    // stop with the accept that fills the last address
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 16'(16'h20 + i), 1'b0);
    cyc(1'b0, 1'b1, 16'h0027, 1'b1);
    check("laststop.full", 32'(full_s), 32'd1);
    check("laststop.notdone", 32'(done_s), 32'd0);
    idle(1);
    check("laststop.done", 32'(done_s), 32'd1);
    read_chk("laststop.ram0", 0, 20'h00201);
    read_chk("laststop.ram7", 7, 20'h00271);

    // asynchronous reset between edges mid-capture
    do_reset();
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0030, 1'b0);
    cyc(1'b0, 1'b1, 16'h0031, 1'b0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async.count", 32'(count_s), 32'd0);
    check("async.in_ready", 32'(if_s.in_ready), 32'd0);
    check("async.rd_data", 32'(rd_data_s), 32'd0);
    check("async.done", 32'(done_d), 32'd0);
    tick();
    reset = 1'b0;
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b1, 16'h0077, 1'b0);
    idle(1);
    check("restart.count", 32'(count_s), 32'd1);
    read_chk("restart.ram0", 0, 20'h00771);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000");
    $fatal(1);
  end

endmodule
